// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - decodes a scanned 7-segment display back into a BCD frame
//
// Purpose
//   Watches the segment and digit-select lines of a multiplexed 6-digit
//   7-segment display and rebuilds the displayed value. A {dig_sel, seg7}
//   sample must stay unchanged for STABLE_CYCLES consecutive cycles before
//   it is accepted. This rejects ghosting during digit changeover.
//   Accepted samples with exactly one digit selected are decoded into that
//   digit's slot. Once all six slots have been collected, the frame is
//   published to the outputs and held until the consumer acknowledges it.
//
// Configuration
//   SEG7_HEX_DECODE_EN - when defined, the glyphs A b C d E F decode to
//                        4'hA..4'hF. When undefined, they count as
//                        undecodable patterns.
//
// Parameters
//   STABLE_CYCLES - consecutive identical cycles before a sample is accepted (2..255)
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   seg7_in      in   [6:0] segment lines, active-low, bit0=a .. bit6=g
//   dig_sel_in   in   [5:0] digit enables, active-low, bit k low selects digit k
//   frame_ack    in   consumer acknowledge of the published frame
//   bcd_out      out  [23:0] published frame, digit k in bits [4k+3:4k]
//   blank_out    out  [5:0] digit k was blank (all segments off)
//   err_out      out  [5:0] digit k held an undecodable pattern
//   frame_valid  out  published frame available, held until acknowledged
//   overrun_out  out  sticky, a completed frame was dropped

module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg7_in,
    input  logic [5:0]  dig_sel_in,
    input  logic        frame_ack,
    output logic [23:0] bcd_out,
    output logic [5:0]  blank_out,
    output logic [5:0]  err_out,
    output logic        frame_valid,
    output logic        overrun_out
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_CYCLES - 2);
    localparam logic [5:0]    MASK_FULL  = 6'b111111;

    typedef enum logic {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    // Result of decoding one glyph: nibble plus blank/err classification.
    typedef struct packed {
        logic       blank;
        logic       err;
        logic [3:0] nibble;
    } glyph_t;

    // ------------------------------------------------------------------
    // Glyph decode. The patterns are written g..a, matching seg7_in[6:0].
    // ------------------------------------------------------------------
    function automatic glyph_t decode_glyph(input logic [6:0] seg);
        glyph_t g;
        g = '{blank: 1'b0, err: 1'b0, nibble: 4'h0};
        case (seg)
            7'b1000000: g.nibble = 4'h0;
            7'b1111001: g.nibble = 4'h1;
            7'b0100100: g.nibble = 4'h2;
            7'b0110000: g.nibble = 4'h3;
            7'b0011001: g.nibble = 4'h4;
            7'b0010010: g.nibble = 4'h5;
            7'b0000010: g.nibble = 4'h6;
            7'b1111000: g.nibble = 4'h7;
            7'b0000000: g.nibble = 4'h8;
            7'b0010000: g.nibble = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
            7'b0001000: g.nibble = 4'hA;
            7'b0000011: g.nibble = 4'hB;
            7'b1000110: g.nibble = 4'hC;
            7'b0100001: g.nibble = 4'hD;
            7'b0000110: g.nibble = 4'hE;
            7'b0001110: g.nibble = 4'hF;
`endif
            7'b1111111: g.blank  = 1'b1;
            default:    g.err    = 1'b1;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Report whether exactly one digit-select line is low, and which one.
    // ------------------------------------------------------------------
    function automatic logic [3:0] single_low(input logic [5:0] sel);
        logic [2:0] idx;
        int         lows;
        idx  = 3'd0;
        lows = 0;
        for (int k = 0; k < 6; k++) begin
            if (!sel[k]) begin
                lows = lows + 1;
                idx  = 3'(k);
            end
        end
        return {(lows == 1), idx};
    endfunction

    // ------------------------------------------------------------------
    // Sampler and stability counter
    // ------------------------------------------------------------------
    logic [12:0]   sample;
    logic [CW-1:0] count;
    logic [12:0]   sample_next;
    logic          same;
    logic          accept;

    assign sample_next = {dig_sel_in, seg7_in};
    assign same        = (sample_next == sample);
    // The count becomes STABLE_CYCLES-1 on this edge. Because the counter
    // saturates above that value, this point is reached only once per stable run.
    assign accept      = same && (count == CNT_ACCEPT);

    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= '0;
            count  <= '0;
        end else begin
            sample <= sample_next;
            if (!same) begin
                count <= '0;
            end else if (count != CNT_SAT) begin
                count <= count + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot write decode. The accepted value is the sample register itself,
    // which already equals the input on an accept cycle.
    // ------------------------------------------------------------------
    logic [3:0] sel_info;
    logic       sel_one;
    logic [2:0] sel_idx;
    glyph_t     glyph;
    logic       slot_we;
    logic [5:0] slot_bit;

    assign sel_info = single_low(sample[12:7]);
    assign sel_one  = sel_info[3];
    assign sel_idx  = sel_info[2:0];
    assign glyph    = decode_glyph(sample[6:0]);
    assign slot_we  = accept && sel_one;
    assign slot_bit = slot_we ? (6'b000001 << sel_idx) : 6'b000000;

    // ------------------------------------------------------------------
    // Collection registers and COLLECT/PUBLISH state machine
    // ------------------------------------------------------------------
    state_t      state;
    logic [23:0] slot_bcd;
    logic [5:0]  slot_blank;
    logic [5:0]  slot_err;
    logic [5:0]  mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            slot_bcd    <= '0;
            slot_blank  <= '0;
            slot_err    <= '0;
            mask        <= '0;
            bcd_out     <= '0;
            blank_out   <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            // Slots are written in both states. A later accept for the
            // same digit overwrites the earlier value.
            if (slot_we) begin
                slot_bcd[{sel_idx, 2'b00} +: 4] <= glyph.nibble;
                slot_blank[sel_idx]             <= glyph.blank;
                slot_err[sel_idx]               <= glyph.err;
            end

            case (state)
                COLLECT: begin
                    mask <= mask | slot_bit;
                    if (mask == MASK_FULL) begin
                        state <= PUBLISH;
                    end
                    if (frame_valid && frame_ack) begin
                        frame_valid <= 1'b0;
                    end
                end

                PUBLISH: begin
                    // An ack in this cycle frees the output registers for
                    // the new frame, so the frame is published, not dropped.
                    if (!frame_valid || frame_ack) begin
                        bcd_out     <= slot_bcd;
                        blank_out   <= slot_blank;
                        err_out     <= slot_err;
                        frame_valid <= 1'b1;
                    end else begin
                        overrun_out <= 1'b1;
                    end
                    // If a digit is accepted in this same cycle, keep its
                    // mask bit so it counts toward the next frame.
                    mask  <= slot_bit;
                    state <= COLLECT;
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int S = 4;

    // Glyph tables: index = displayed value
    localparam logic [6:0] DIG_PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] HEX_PAT [6]  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [23:0] bcd;
        logic [5:0]  blank;
        logic [5:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg7_in;
    logic [5:0]  dig_sel_in;
    logic        mon_ack;
    logic        man_ack;
    logic        frame_ack;
    logic [23:0] bcd_out;
    logic [5:0]  blank_out;
    logic [5:0]  err_out;
    logic        frame_valid;
    logic        overrun_out;

    assign frame_ack = mon_ack | man_ack;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg7_in    (seg7_in),
        .dig_sel_in (dig_sel_in),
        .frame_ack  (frame_ack),
        .bcd_out    (bcd_out),
        .blank_out  (blank_out),
        .err_out    (err_out),
        .frame_valid(frame_valid),
        .overrun_out(overrun_out)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    frame_t exp_q[$];
    logic [3:0]  m_val [6];
    logic [5:0]  m_blank, m_err, m_have;
    logic [12:0] prev_in;
    bit          auto_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: a display value held for len cycles counts only if len >= S
    // and exactly one digit is selected. Six distinct digits make a frame.
    function automatic void model_hold(input logic [5:0] sel, input logic [6:0] seg, input int len);
        int     lows, k;
        logic [3:0] v;
        logic   b, e;
        frame_t f;
        lows = 0; k = 0;
        for (int i = 0; i < 6; i++) if (!sel[i]) begin lows++; k = i; end
        if (len < S || lows != 1) return;
        v = 4'h0; b = 1'b0; e = 1'b1;
        if (seg == 7'h7F) begin b = 1'b1; e = 1'b0; end
        for (int i = 0; i < 10; i++) if (seg == DIG_PAT[i]) begin v = 4'(i); e = 1'b0; end
`ifdef SEG7_HEX_DECODE_EN
        for (int i = 0; i < 6; i++) if (seg == HEX_PAT[i]) begin v = 4'(10 + i); e = 1'b0; end
`endif
        m_val[k] = v; m_blank[k] = b; m_err[k] = e; m_have[k] = 1'b1;
        if (m_have == 6'h3F) begin
            for (int i = 0; i < 6; i++) f.bcd[4*i +: 4] = m_val[i];
            f.blank = m_blank;
            f.err   = m_err;
            exp_q.push_back(f);
            m_have = '0;
        end
    endfunction

    // mode 0: plain hold; 1: also check publish latency; 2: ack in the PUBLISH cycle
    task automatic hold(input logic [5:0] sel, input logic [6:0] seg, input int len, input int mode);
        @(negedge clk);
        dig_sel_in = sel;
        seg7_in    = seg;
        prev_in    = {sel, seg};
        model_hold(sel, seg, len);
        if (mode == 0) begin
            repeat (len) @(posedge clk);
        end else begin
            repeat (S + 1) @(posedge clk);
            @(negedge clk);
            if (mode == 1) chk("latency_early_valid", frame_valid, 0);
            else           man_ack = 1'b1;
            @(posedge clk);
            #1;
            man_ack = 1'b0;
            if (mode == 1) chk("latency_valid", frame_valid, 1);
            repeat (len - S - 2) @(posedge clk);
        end
    endtask

    function automatic logic [5:0] sel_of(input int k);
        logic [5:0] s;
        s = 6'b000001 << k;
        return ~s;
    endfunction

    // Digits 0..5 show vals[0..5]; last digit optionally uses a check mode
    task automatic frame(input int v0, input int v1, input int v2, input int v3,
                         input int v4, input int v5, input int last_mode);
        int vals[6];
        vals = '{v0, v1, v2, v3, v4, v5};
        for (int k = 0; k < 5; k++) hold(sel_of(k), DIG_PAT[vals[k]], 6, 0);
        hold(sel_of(5), DIG_PAT[vals[5]], (last_mode == 0) ? 6 : S + 3, last_mode);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        dig_sel_in = 6'h3F;
        seg7_in    = 7'h7F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        prev_in = 13'h1FFF;
        m_have = '0; m_blank = '0; m_err = '0;
        for (int i = 0; i < 6; i++) m_val[i] = 4'h0;
        exp_q.delete();
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) chk("drain_timeout_pending", 32'(exp_q.size()), 0);
        repeat (4) @(posedge clk);
    endtask

    // Monitor: compare every presented frame with the scoreboard, then ack it
    initial begin
        frame_t e;
        mon_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_ack) begin
                mon_ack = 1'b0;
            end else if (auto_ack && !rst && frame_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {8'h0, bcd_out}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_bcd", {8'h0, bcd_out}, {8'h0, e.bcd});
                    chk("frame_blank", {26'h0, blank_out}, {26'h0, e.blank});
                    chk("frame_err", {26'h0, err_out}, {26'h0, e.err});
                end
                mon_ack = 1'b1;
            end
        end
    end

    initial begin
        frame_t fa, fb;
        logic [5:0] rs;
        logic [6:0] rg;
        int r;
        rst = 1'b1; man_ack = 1'b0; auto_ack = 1'b1;
        dig_sel_in = 6'h3F; seg7_in = 7'h7F;
        do_reset();
        chk("reset_bcd", {8'h0, bcd_out}, 0);
        chk("reset_blank", {26'h0, blank_out}, 0);
        chk("reset_err", {26'h0, err_out}, 0);
        chk("reset_valid", frame_valid, 0);
        chk("reset_overrun", overrun_out, 0);

        // 1..6 on digits 0..5
        frame(1, 2, 3, 4, 5, 6, 0);
        drain();

        // digit 2 toggles too fast, then settles on 1; it is the last digit needed
        for (int k = 0; k < 6; k++) if (k != 2) hold(sel_of(k), DIG_PAT[k + 3], 6, 0);
        for (int t = 0; t < 10; t++) hold(sel_of(2), (t % 2) ? 7'h30 : 7'h24, 2, 0);
        hold(sel_of(2), 7'h79, 6, 0);
        drain();

        // blank and undecodable digits
        for (int k = 0; k < 4; k++) hold(sel_of(k), DIG_PAT[9 - k], 6, 0);
        hold(sel_of(4), 7'h7F, 6, 0);
        hold(sel_of(5), 7'h36, 6, 0);
        drain();

        // two digits selected at once, then a normal frame
        hold(6'b111100, 7'h40, 8, 0);
        frame(7, 8, 9, 0, 1, 2, 0);
        drain();

        // hex glyph A on digit 0
        hold(sel_of(0), HEX_PAT[0], 6, 0);
        for (int k = 1; k < 6; k++) hold(sel_of(k), DIG_PAT[k], 6, 0);
        drain();

        // reset mid-collection discards partial data
        for (int k = 0; k < 3; k++) hold(sel_of(k), DIG_PAT[8], 6, 0);
        do_reset();
        frame(2, 4, 6, 8, 0, 1, 0);
        drain();

        // randomized scanning
        for (int n = 0; n < 400; n++) begin
            do begin
                if ($urandom_range(0, 4) != 0) rs = sel_of($urandom_range(0, 5));
                else                           rs = 6'($urandom);
                r = $urandom_range(0, 9);
                if (r <= 5)      rg = DIG_PAT[$urandom_range(0, 9)];
                else if (r == 6) rg = HEX_PAT[$urandom_range(0, 5)];
                else if (r == 7) rg = 7'h7F;
                else             rg = 7'($urandom);
            end while ({rs, rg} == prev_in);
            hold(rs, rg, $urandom_range(1, 8), 0);
        end
        drain();
        chk("random_overrun", overrun_out, 0);

        // unacknowledged second frame is dropped
        auto_ack = 1'b0;
        do_reset();
        frame(1, 2, 3, 4, 5, 6, 1);
        frame(6, 5, 4, 3, 2, 1, 0);
        repeat (5) @(posedge clk);
        #1;
        fa = exp_q.pop_front();
        fb = exp_q.pop_front();
        chk("ovr_valid", frame_valid, 1);
        chk("ovr_first_kept", {8'h0, bcd_out}, {8'h0, fa.bcd});
        chk("ovr_flag", overrun_out, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_sticky", overrun_out, 1);

        // ack in the PUBLISH cycle of the second frame lets it through
        do_reset();
        chk("ovr_cleared_by_reset", overrun_out, 0);
        frame(9, 8, 7, 6, 5, 4, 0);
        repeat (4) @(posedge clk);
        #1;
        fa = exp_q.pop_front();
        chk("ack_first_valid", frame_valid, 1);
        chk("ack_first_bcd", {8'h0, bcd_out}, {8'h0, fa.bcd});
        frame(3, 1, 4, 1, 5, 9, 2);
        fb = exp_q.pop_front();
        chk("ack_second_valid", frame_valid, 1);
        chk("ack_second_bcd", {8'h0, bcd_out}, {8'h0, fb.bcd});
        chk("ack_second_overrun", overrun_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
